// File: rtl/store_pkg.sv
// Shared store/load size encoding and lane helpers.
// Used by the store queue and the load-side data extractor.
package store_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int ADDR_W_DEF = 32;
    // Entry layout: {word addr, wdata[31:0], wstrb[3:0]}
    localparam int LANE_W  = 36;
    localparam int ENTRY_W = ADDR_W_DEF + LANE_W;

    // Replicate right-justified data across all lanes
    function automatic logic [31:0] lane_data(
        input logic [1:0]  size,
        input logic [31:0] data
    );
        logic [31:0] r;
        r = {4{data[7:0]}};
        if (size[1])
            r = data;
        else if (size[0])
            r = {2{data[15:0]}};
        return r;
    endfunction

    function automatic logic [3:0] lane_strb(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [3:0] r;
        r = 4'b0001 << off;
        if (size[1])
            r = 4'b1111;
        else if (size[0])
            r = off[1] ? 4'b1100 : 4'b0011;
        return r;
    endfunction

    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic r;
        r = 1'b0;
        if (size[1])
            r = (off != 2'b00);
        else if (size[0])
            r = off[0];
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-two depth, sync active-high reset.
// Ports: push/din, pop/dout (head), full, empty, count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[head];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[tail] <= din;
                tail      <= tail + PTR_W'(1);
            end
            if (do_pop)
                head <= head + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/store_queue.sv
// Store queue: aligns CPU stores into word bus writes and buffers them.
// Ports: req_* (store in), mem_* (write out), misalign, empty, count.
module store_queue
    import store_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    output logic              misalign,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int EW = ADDR_W + LANE_W;

    logic [1:0]    off;
    logic          accept;
    logic          bad;
    logic          push;
    logic          pop;
    logic          full;
    logic          fifo_empty;
    logic [EW-1:0] din;
    logic [EW-1:0] dout;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;

    assign off    = req_addr[1:0];
    assign wdata  = lane_data(req_size, req_data);
    assign wstrb  = lane_strb(req_size, off);
    assign bad    = is_misaligned(req_size, off);

    // Ready comes only from registered occupancy, never from mem_ready
    assign req_ready = !full;
    assign accept    = req_valid && req_ready;
    assign push      = accept && !bad;
    assign pop       = mem_valid && mem_ready;

    assign din = {req_addr[ADDR_W-1:2], 2'b00, wdata, wstrb};

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (dout),
        .full  (full),
        .empty (fifo_empty),
        .count (count)
    );

    assign mem_valid = !fifo_empty;
    assign empty     = fifo_empty;
    assign mem_addr  = dout[EW-1 -: ADDR_W];
    assign mem_wdata = dout[35:4];
    assign mem_wstrb = dout[3:0];

    // Dropped misaligned store is reported the cycle after acceptance
    always_ff @(posedge clk) begin
        if (rst)
            misalign <= 1'b0;
        else
            misalign <= accept && bad;
    end

endmodule

// File: doc/store_queue.md
# store_queue

Write-side counterpart of the load data extractor: accepts CPU store requests (address, size, raw register data), converts them into word-aligned bus writes with replicated lane data and byte strobes, and buffers them in a small FIFO ahead of the memory write port. Sits between the execute stage and the data-memory/bus write channel. Misaligned stores are flagged and dropped.

## Interface
Parameters:
- DEPTH, 4, number of buffered stores; power of two, ≥ 2
- ADDR_W, 32, address width

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- req_valid  in  1  store request valid
- req_ready  out  1  queue can accept a request
- req_addr  in  ADDR_W  byte address
- req_size  in  2  00 byte, 01 half, 1x word (same encoding as load side)
- req_data  in  32  store data, right-justified
- mem_valid  out  1  head entry valid
- mem_ready  in  1  memory accepts head entry
- mem_addr  out  ADDR_W  word address, bits [1:0] forced 0
- mem_wdata  out  32  lane-replicated write data
- mem_wstrb  out  4  byte enables
- misalign  out  1  one-cycle pulse: a misaligned store was dropped
- empty  out  1  queue holds no entries (used by fences/loads)
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Request handshake: accepted when req_valid && req_ready. req_ready = (count != DEPTH); no same-cycle bypass from pop.
- Alignment, off = req_addr[1:0]:
  - byte: wdata = {4{data[7:0]}}, wstrb = 4'b0001 << off; never misaligned.
  - half: wdata = {2{data[15:0]}}, wstrb = off[1] ? 4'b1100 : 4'b0011; misaligned if off[0].
  - word (size[1]=1): wdata = data, wstrb = 4'b1111; misaligned if off != 0.
- Misaligned accepted request: consumed (handshake completes), not enqueued, count unchanged; misalign = 1 in the following cycle only.
- Aligned accepted request: entry {addr & ~3, wdata, wstrb} written at tail; tail++ (wraps modulo DEPTH); count++.
- Pop: mem_valid && mem_ready → head++ (wraps); count--.
- Simultaneous push and pop: both pointers advance, count unchanged.
- Order strictly FIFO; no merging or coalescing of stores.
- mem_valid = (count != 0); empty = (count == 0).
- Reset (any time, including mid-operation): count, head, tail, misalign cleared; all buffered stores discarded; storage cleared so mem_addr/mem_wdata/mem_wstrb read 0.

## Timing
- Reset values: req_ready 1, mem_valid 0, mem_addr 0, mem_wdata 0, mem_wstrb 0, misalign 0, empty 1, count 0.
- Latency: store accepted in cycle N → mem_valid earliest in N+1 with its data.
- mem_addr/mem_wdata/mem_wstrb stable while mem_valid && !mem_ready.
- Full (count == DEPTH): req_ready low that cycle even if mem_ready high; rises the cycle after a pop.
- Sustained throughput 1 store/cycle when mem_ready held high and queue not full.
- misalign pulse and any push/pop in the same cycle are independent.
- req_ready depends only on registered count (no combinational path from mem_ready).

## Structure
- Shared package store_pkg: SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10, ENTRY_W = ADDR_W+36 layout constants; load-side extractor uses the same size constants.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count, synchronous active-high reset). Alignment and misalign detection stay combinational in store_queue.

## Test plan
- Byte store addr 0x103, data 0x000000AB → mem_addr 0x100, mem_wdata 0xABABABAB, mem_wstrb 0b1000, one cycle after accept.
- Half store addr 0x202, data 0x1234 → mem_addr 0x200, mem_wdata 0x12341234, mem_wstrb 0b1100; word store addr 0x204, data 0xDEADBEEF → wstrb 0b1111.
- Misaligned half at 0x301 and word at 0x302 → each accepted, count stays 0, misalign high exactly one cycle after each, no mem_valid.
- mem_ready held 0, issue 5 stores with DEPTH=4 → req_ready low after 4th, 5th stalls; release mem_ready → drained in order, 5th accepted the cycle after first pop.
- mem_ready=1 continuous, back-to-back stores → one write per cycle, count oscillates ≤ 1, pointer wrap after DEPTH entries preserves order.
- Fill 3 entries, assert rst one cycle → next cycle count 0, mem_valid 0, empty 1, req_ready 1; old entries never appear.
